pulse_meter: RTL and testbench

Downstream consumer of the credit holder's serial `out` pulse. It measures the pulse length in divider ticks and recovers the credited total. The total is converted to 3-digit BCD and driven onto a multiplexed 4-digit common-anode seven-segment display. The block runs on sysclk and qualifies its counting with the divided tick, so the holder and this block share one timebase.

---
 rtl/pulse_meter_pkg.sv | 29 ++
 rtl/pulse_meter_if.sv | 28 ++
 rtl/pulse_meter_seg_mux.sv | 49 ++++
 rtl/pulse_meter.sv | 190 +++++++++++++++++++
 tb/tb_pulse_meter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_meter_pkg.sv
// rtl/pulse_meter_pkg.sv - shared types and constants for the pulse meter
// Segment patterns are active-low with bit 0 = segment a, bit 6 = segment g.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int CONV_W  = 10;
  localparam int BCD_W   = 12;
  localparam int SUM_MAX = 999;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;

  // Entry 0 is the rightmost element.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    digit_seg = (d <= 4'd9) ? SEG_DIGITS[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/pulse_meter_if.sv
// rtl/pulse_meter_if.sv - pulse meter measurement and display signal bundle
interface pulse_meter_if
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W = 9
) ();

  logic             tick;
  logic             pulse_in;
  logic [CNT_W-1:0] len;
  logic [BCD_W-1:0] bcd;
  logic             valid;
  logic             ovf;
  logic             busy;
  logic [6:0]       seg;
  logic [3:0]       an;

  modport master (
    output tick, pulse_in,
    input  len, bcd, valid, ovf, busy, seg, an
  );

  modport slave (
    input  tick, pulse_in,
    output len, bcd, valid, ovf, busy, seg, an
  );

endinterface

// File: rtl/pulse_meter_seg_mux.sv
// rtl/pulse_meter_seg_mux.sv - 4-digit multiplexed common-anode display driver
// Digits 0..2 show BCD units..hundreds; digit 3 shows 'E' on overflow.
module seg_mux
  import pulse_meter_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [BCD_W-1:0] i_bcd,
  input  logic             i_ovf,
  output logic [6:0]       o_seg,
  output logic [3:0]       o_an
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [RW-1:0] r_ref;
  logic [1:0]    r_idx;
  logic [6:0]    w_seg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ref <= '0;
      r_idx <= '0;
    end else if (r_ref == RW'(REFRESH_DIV - 1)) begin
      r_ref <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_ref <= r_ref + RW'(1);
    end
  end

  always_comb begin
    w_seg = SEG_BLANK;
    case (r_idx)
      2'd0: w_seg = digit_seg(i_bcd[3:0]);
      2'd1: w_seg = digit_seg(i_bcd[7:4]);
      2'd2: w_seg = digit_seg(i_bcd[11:8]);
      2'd3: w_seg = i_ovf ? SEG_E : SEG_BLANK;
      default: w_seg = SEG_BLANK;
    endcase
  end

  // Display stays dark for as long as reset is held, not just after the edge.
  assign o_seg = i_rst ? SEG_BLANK : w_seg;
  assign o_an  = i_rst ? 4'hF : ~(4'b0001 << r_idx);

endmodule

// File: rtl/pulse_meter.sv
// rtl/pulse_meter.sv - measures holder pulse length in ticks, converts to BCD, drives display
// Optional PULSE_METER_ACCUM_EN: bcd shows a running sum of measurements saturating at 999.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W       = 9,
  parameter int LEN_OFFSET  = 1,
  parameter int REFRESH_DIV = 50000
) (
  input  logic         sysclk,
  input  logic         rst,
  pulse_meter_if.slave pm
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] OFFS     = CNT_W'(LEN_OFFSET);
  localparam logic [3:0]       BIT_LAST = 4'(CONV_W - 1);

  logic             r_s1, r_s2, r_d;
  logic [1:0]       r_fill;
  logic             r_armed;
  logic             w_rise, w_fall;

  state_t           r_state, w_state_n;
  logic             w_busy;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf_n;
  logic [CONV_W-1:0] r_value;
  logic [CONV_W-1:0] r_bin;
  logic [BCD_W-1:0]  r_shift;
  logic [BCD_W-1:0]  w_adj;
  logic [3:0]        r_bit;
  logic [CONV_W-1:0] w_value;
  logic [CONV_W-1:0] w_conv_src;

  logic [CNT_W-1:0] r_len;
  logic [BCD_W-1:0] r_bcd;
  logic             r_ovf;
  logic             r_valid;
  logic [6:0]       w_seg;
  logic [3:0]       w_an;

  // r_armed blocks a false rise when pulse_in is already high as reset releases.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_d     <= 1'b0;
      r_fill  <= 2'd0;
      r_armed <= 1'b0;
    end else begin
      r_s1    <= pm.pulse_in;
      r_s2    <= r_s1;
      r_d     <= r_s2;
      r_fill  <= (r_fill == 2'd2) ? 2'd2 : r_fill + 2'd1;
      r_armed <= r_armed | ((r_fill == 2'd2) && !r_s2);
    end
  end

  assign w_rise = r_s2 & ~r_d & r_armed;
  assign w_fall = ~r_s2 & r_d;

  assign w_value = (r_cnt >= OFFS) ? CONV_W'(r_cnt - OFFS) : '0;

`ifdef PULSE_METER_ACCUM_EN
  logic [CONV_W-1:0] r_sum;
  logic [CONV_W:0]   w_sum_raw;

  assign w_sum_raw  = {1'b0, r_sum} + {1'b0, w_value};
  assign w_conv_src = (w_sum_raw > (CONV_W + 1)'(SUM_MAX)) ? CONV_W'(SUM_MAX)
                                                           : w_sum_raw[CONV_W-1:0];

  // The sum commits when conversion starts; only reset can abandon it and reset clears it.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_sum <= '0;
    end else if ((r_state == MEASURE) && w_fall) begin
      r_sum <= w_conv_src;
    end
  end
`else
  assign w_conv_src = w_value;
`endif

  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_busy    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) w_state_n = MEASURE;
      end
      MEASURE: begin
        w_busy = 1'b1;
        if (w_fall) w_state_n = CONVERT;
      end
      CONVERT: begin
        w_busy = 1'b1;
        if (r_bit == BIT_LAST) w_state_n = DONE;
      end
      DONE: begin
        w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_shift;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (r_shift[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_shift[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_ovf_n <= 1'b0;
      r_value <= '0;
      r_bin   <= '0;
      r_shift <= '0;
      r_bit   <= '0;
      r_len   <= '0;
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_cnt   <= '0;
            r_ovf_n <= 1'b0;
          end
        end
        MEASURE: begin
          // A fall always ends the measurement; p_s is already low so no tick counts.
          if (w_fall) begin
            r_value <= w_value;
            r_bin   <= w_conv_src;
            r_shift <= '0;
            r_bit   <= '0;
          end else if (pm.tick && r_s2 && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_MAX - CNT_W'(1)) r_ovf_n <= 1'b1;
          end
        end
        CONVERT: begin
          {r_shift, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
          r_bit            <= r_bit + 4'd1;
        end
        DONE: begin
          r_len   <= CNT_W'(r_value);
          r_bcd   <= r_shift;
          r_ovf   <= r_ovf_n;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  seg_mux #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_seg_mux (
    .i_clk (sysclk),
    .i_rst (rst),
    .i_bcd (r_bcd),
    .i_ovf (r_ovf),
    .o_seg (w_seg),
    .o_an  (w_an)
  );

  assign pm.len   = r_len;
  assign pm.bcd   = r_bcd;
  assign pm.valid = r_valid;
  assign pm.ovf   = r_ovf;
  assign pm.busy  = w_busy;
  assign pm.seg   = w_seg;
  assign pm.an    = w_an;

endmodule

// File: tb/tb_pulse_meter.sv
// tb/tb_pulse_meter.sv - self-checking bench for pulse_meter
// Pulse lengths are counted from tick phase arithmetic; bcd from decimal division.
module tb_pulse_meter;

  localparam int CNT_W      = 9;
  localparam int LEN_OFFSET = 1;
  localparam int RD         = 8;
  localparam int TP         = 4;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic sysclk = 1'b0;
  logic rst    = 1'b1;
  always #5 sysclk = ~sysclk;

  pulse_meter_if #(.CNT_W(CNT_W)) pm ();

  pulse_meter #(
    .CNT_W       (CNT_W),
    .LEN_OFFSET  (LEN_OFFSET),
    .REFRESH_DIV (RD)
  ) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .pm     (pm)
  );

  typedef struct {
    int len_cycles;
    int exp_len;
    int exp_bcd;
    int exp_ovf;
  } vec_t;

  vec_t vecs [6];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int cap_n, cap_cyc, cap_len, cap_bcd, cap_ovf;
  int msum  = 0;

  function automatic int to_bcd(input int v);
    return (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int model_bcd(input int len);
`ifdef PULSE_METER_ACCUM_EN
    msum = (msum + len > 999) ? 999 : msum + len;
    return to_bcd(msum);
`else
    return to_bcd(len);
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  task automatic step(input logic p, input logic r);
    @(posedge sysclk);
    #1;
    cyc++;
    pm.tick     = ((cyc % TP) == TP - 1);
    pm.pulse_in = p;
    rst         = r;
    #1;
    if (pm.valid === 1'b1) begin
      cap_n++;
      cap_cyc = cyc;
      cap_len = int'(pm.len);
      cap_bcd = int'(pm.bcd);
      cap_ovf = int'(pm.ovf);
    end
  endtask

  task automatic meas(input int len_cycles, input int gap, input bit align,
                      output int elen, output int eovf);
    int a, raw, cnt;
    if (align) while (((cyc + 1) % TP) != 0) step(1'b0, 1'b0);
    cap_n = 0;
    a = cyc + 1;
    repeat (len_cycles) step(1'b1, 1'b0);
    repeat (gap) step(1'b0, 1'b0);
    raw = 0;
    for (int c = a + 3; c <= a + len_cycles + 1; c++) if ((c % TP) == TP - 1) raw++;
    cnt  = (raw > CMAX) ? CMAX : raw;
    eovf = (raw >= CMAX) ? 1 : 0;
    elen = (cnt >= LEN_OFFSET) ? cnt - LEN_OFFSET : 0;
    chk("valid_count", cap_n, 1);
    chk("valid_latency", cap_cyc, a + len_cycles + 14);
  endtask

  task automatic disp(input int ebcd, input int eovf);
    int bad, idx;
    logic [3:0] seen;
    logic [6:0] es;
    bad  = 0;
    seen = 4'h0;
    repeat (4 * RD + 2) begin
      step(1'b0, 1'b0);
      case (pm.an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0) begin
        bad++;
      end else begin
        seen[idx] = 1'b1;
        es = (idx == 3) ? (eovf != 0 ? 7'b0000110 : 7'b1111111)
                        : ref_seg((ebcd >> (4 * idx)) & 15);
        if (pm.seg !== es) bad++;
      end
    end
    chk("display_bad_samples", bad, 0);
    chk("display_digits_seen", int'(seen), 15);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_seg"},   int'(pm.seg),   'h7F);
    chk({tag, "_an"},    int'(pm.an),    'hF);
    chk({tag, "_len"},   int'(pm.len),   0);
    chk({tag, "_bcd"},   int'(pm.bcd),   0);
    chk({tag, "_ovf"},   int'(pm.ovf),   0);
    chk({tag, "_valid"}, int'(pm.valid), 0);
    chk({tag, "_busy"},  int'(pm.busy),  0);
  endtask

  initial begin
    int elen, eovf, eb, L;
    pm.tick     = 1'b0;
    pm.pulse_in = 1'b0;

    vecs[0] = '{89 * TP,     88, 'h088, 0};
    vecs[1] = '{257 * TP,   256, 'h256, 0};
    vecs[2] = '{600 * TP,   510, 'h510, 1};
    vecs[3] = '{33 * TP,     32, 'h032, 0};
    vecs[4] = '{1 * TP,       0, 'h000, 0};
    vecs[5] = '{10 * TP + 1,  9, 'h009, 0};

    repeat (3) step(1'b0, 1'b1);
    chk_reset_outputs("reset");
    repeat (5) step(1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      meas(vecs[i].len_cycles, 20, 1'b1, elen, eovf);
`ifdef PULSE_METER_ACCUM_EN
      eb = model_bcd(vecs[i].exp_len);
`else
      eb = vecs[i].exp_bcd;
`endif
      chk("table_len", cap_len, vecs[i].exp_len);
      chk("table_bcd", cap_bcd, eb);
      chk("table_ovf", cap_ovf, vecs[i].exp_ovf);
      disp(eb, vecs[i].exp_ovf);
    end

    // Reset mid-MEASURE with pulse_in still high after release.
    while (((cyc + 1) % TP) != 0) step(1'b0, 1'b0);
    cap_n = 0;
    repeat (100) step(1'b1, 1'b0);
    chk("busy_in_measure", int'(pm.busy), 1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk_reset_outputs("rst_measure");
    msum = 0;
    repeat (60) step(1'b1, 1'b0);
    chk("idle_after_release_high", int'(pm.busy), 0);
    repeat (30) step(1'b0, 1'b0);
    chk("no_valid_after_abort", cap_n, 0);
    meas(89 * TP, 20, 1'b1, elen, eovf);
    chk("post_reset_len", cap_len, 88);
    chk("post_reset_bcd", cap_bcd, model_bcd(88));

    // Reset mid-CONVERT.
    while (((cyc + 1) % TP) != 0) step(1'b0, 1'b0);
    cap_n = 0;
    repeat (200) step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    chk("busy_in_convert", int'(pm.busy), 1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk_reset_outputs("rst_convert");
    msum = 0;
    repeat (30) step(1'b0, 1'b0);
    chk("no_valid_after_convert_abort", cap_n, 0);
    meas(33 * TP, 20, 1'b1, elen, eovf);
    chk("post_conv_reset_len", cap_len, 32);
    chk("post_conv_reset_ovf", cap_ovf, 0);
    chk("post_conv_reset_bcd", cap_bcd, model_bcd(32));

    for (int i = 0; i < 20; i++) begin
      L = (i % 5 == 4) ? $urandom_range(2000, 2300) : $urandom_range(1, 900);
      repeat ($urandom_range(0, 3)) step(1'b0, 1'b0);
      meas(L, $urandom_range(16, 30), 1'b0, elen, eovf);
      chk("rand_len", cap_len, elen);
      chk("rand_ovf", cap_ovf, eovf);
      chk("rand_bcd", cap_bcd, model_bcd(elen));
    end

`ifdef PULSE_METER_ACCUM_EN
    repeat (3) step(1'b0, 1'b1);
    msum = 0;
    repeat (5) step(1'b0, 1'b0);
    meas(89 * TP, 20, 1'b1, elen, eovf);
    chk("accum_bcd_1", cap_bcd, 'h088);
    meas(81 * TP, 20, 1'b1, elen, eovf);
    chk("accum_bcd_2", cap_bcd, 'h168);
    meas(57 * TP, 20, 1'b1, elen, eovf);
    chk("accum_bcd_3", cap_bcd, 'h224);
    chk("accum_len_3", cap_len, 56);
    msum = 224;
    for (int i = 0; i < 6; i++) begin
      meas(257 * TP, 20, 1'b1, elen, eovf);
      chk("accum_sat_len", cap_len, 256);
      chk("accum_sat_bcd", cap_bcd, model_bcd(256));
    end
    chk("accum_final_999", cap_bcd, 'h999);
    disp('h999, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
